// File: rtl/pe_cfg_pkg.sv
// Shared types and constants for the PE tile configuration loader.
// The CHECK state and checksum fold exist only when PE_CFG_CHECKSUM_EN is defined.
package pe_cfg_pkg;

   localparam logic [7:0] PE_CFG_SYNC  = 8'hA5;
   localparam logic [2:0] ALU_FUNC_MAX = 3'd5;
   localparam int         CTRL_W       = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_DISCARD = 3'd2,
`ifdef PE_CFG_CHECKSUM_EN
      ST_CHECK   = 3'd4,
`endif
      ST_COMMIT  = 3'd3
   } pe_cfg_state_t;

   // Control word layout: in_sel [9:4], out_reg_en [3], alu_func [2:0]
   typedef struct packed {
      logic [5:0] in_sel;
      logic       out_reg_en;
      logic [2:0] alu_func;
   } pe_cfg_ctrl_t;

   function automatic logic alu_func_legal(input logic [2:0] func);
      return (func <= ALU_FUNC_MAX);
   endfunction

`ifdef PE_CFG_CHECKSUM_EN
   function automatic logic [31:0] cfg_chk_fold(input logic [31:0] acc, input logic [31:0] word);
      return acc ^ word;
   endfunction
`endif

endpackage

// File: rtl/pe_cfg_hdr_decode.sv
// Combinational decode of a configuration frame header (word bits [31:8]).
module pe_cfg_hdr_decode
   import pe_cfg_pkg::*;
#(
   parameter logic [7:0]  TILE_ID   = 8'd0,
   parameter int unsigned MAX_WORDS = 4
) (
   input  logic [23:0] hdr,
   output logic        is_sync,
   output logic        id_match,
   output logic        count_ok,
   output logic [7:0]  count
);

   // Field extraction and range check of the payload count
   always_comb begin
      count    = hdr[7:0];
      is_sync  = (hdr[23:16] == PE_CFG_SYNC);
      id_match = (hdr[15:8] == TILE_ID);
      count_ok = (hdr[7:0] >= 8'd2) && (hdr[7:0] <= 8'(MAX_WORDS));
   end

endmodule

// File: rtl/pe_config_loader.sv
// Decodes per-tile configuration frames and commits ALU settings atomically.
// Optional trailing XOR checksum word is enabled by defining PE_CFG_CHECKSUM_EN.
module pe_config_loader
   import pe_cfg_pkg::*;
#(
   parameter logic [7:0]  TILE_ID   = 8'd0,
   parameter int unsigned MAX_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [31:0] cfg_data,
   output logic [2:0]  alu_func,
   output logic [5:0]  in_sel,
   output logic        out_reg_en,
   output logic [31:0] cfg_const,
   output logic        cfg_loaded,
   output logic        cfg_err,
   output logic        cfg_busy
);

   logic          is_sync_s;
   logic          id_match_s;
   logic          count_ok_s;
   logic [7:0]    count_s;
   pe_cfg_state_t state_r;
   pe_cfg_state_t state_nxt_s;
   logic [7:0]    cnt_r;
   logic [1:0]    widx_r;
   logic          pend_r;
   pe_cfg_ctrl_t  sh_ctrl_r;
   logic [31:0]   sh_const_r;
   pe_cfg_ctrl_t  ctrl_in_s;
   pe_cfg_ctrl_t  ctrl_r;
   logic [31:0]   const_r;
   logic          ready_r;
   logic          busy_r;
   logic          loaded_r;
   logic          err_r;
   logic          xfer_s;
   logic          last_s;
   logic          hdr_ok_s;
   logic          commit_s;
   logic          ready_nxt_s;
   logic          busy_nxt_s;
   logic          err_set_s;
   logic          err_clr_s;
`ifdef PE_CFG_CHECKSUM_EN
   logic [31:0]   xor_r;
   logic          chk_bad_s;
`endif

   pe_cfg_hdr_decode #(
      .TILE_ID   (TILE_ID),
      .MAX_WORDS (MAX_WORDS)
   ) u_hdr_decode (
      .hdr      (cfg_data[31:8]),
      .is_sync  (is_sync_s),
      .id_match (id_match_s),
      .count_ok (count_ok_s),
      .count    (count_s)
   );

   assign xfer_s    = cfg_valid & ready_r;
   assign hdr_ok_s  = (state_r == ST_IDLE) & xfer_s & is_sync_s & count_ok_s;
   assign commit_s  = (state_r == ST_COMMIT);
   assign ctrl_in_s = pe_cfg_ctrl_t'(cfg_data[CTRL_W-1:0]);
`ifdef PE_CFG_CHECKSUM_EN
   // The checksum word follows the payload, so the frame ends once the counter has drained
   assign last_s    = (cnt_r == 8'd0);
   assign chk_bad_s = (xor_r != 32'd0);
`else
   assign last_s    = (cnt_r == 8'd1);
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (xfer_s && is_sync_s && count_ok_s) state_nxt_s = id_match_s ? ST_LOAD : ST_DISCARD;
            else state_nxt_s = ST_IDLE;
         end
         ST_LOAD: begin
`ifdef PE_CFG_CHECKSUM_EN
            if (xfer_s && last_s) state_nxt_s = ST_CHECK;
            else state_nxt_s = ST_LOAD;
`else
            if (xfer_s && last_s) state_nxt_s = pend_r ? ST_IDLE : ST_COMMIT;
            else state_nxt_s = ST_LOAD;
`endif
         end
         ST_DISCARD: begin
            if (xfer_s && last_s) state_nxt_s = ST_IDLE;
            else state_nxt_s = ST_DISCARD;
         end
`ifdef PE_CFG_CHECKSUM_EN
         ST_CHECK:  state_nxt_s = (pend_r || chk_bad_s) ? ST_IDLE : ST_COMMIT;
`endif
         ST_COMMIT: state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // Output-side decode: handshake/busy targets and error set/clear events
   always_comb begin
      ready_nxt_s = 1'b0;
      busy_nxt_s  = 1'b1;
      err_set_s   = 1'b0;
      err_clr_s   = 1'b0;
      case (state_nxt_s)
         ST_IDLE: begin
            ready_nxt_s = 1'b1;
            busy_nxt_s  = 1'b0;
         end
         ST_LOAD,
         ST_DISCARD: ready_nxt_s = 1'b1;
         default:    ready_nxt_s = 1'b0;
      endcase
      case (state_r)
         ST_IDLE: begin
            if (xfer_s && is_sync_s && !count_ok_s) err_set_s = 1'b1;
            else err_set_s = 1'b0;
            if (xfer_s && is_sync_s && count_ok_s && id_match_s) err_clr_s = 1'b1;
            else err_clr_s = 1'b0;
         end
`ifdef PE_CFG_CHECKSUM_EN
         ST_CHECK: err_set_s = pend_r | chk_bad_s;
`else
         ST_LOAD: begin
            if (xfer_s && last_s && pend_r) err_set_s = 1'b1;
            else err_set_s = 1'b0;
         end
`endif
         default: err_set_s = 1'b0;
      endcase
   end

   // Frame counter, word index, pending error and shadow registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r      <= 8'd0;
         widx_r     <= 2'd0;
         pend_r     <= 1'b0;
         sh_ctrl_r  <= '0;
         sh_const_r <= 32'd0;
`ifdef PE_CFG_CHECKSUM_EN
         xor_r      <= 32'd0;
`endif
      end else if (hdr_ok_s) begin
         cnt_r  <= count_s;
         widx_r <= 2'd0;
         pend_r <= 1'b0;
`ifdef PE_CFG_CHECKSUM_EN
         xor_r  <= cfg_data;
`endif
      end else if (xfer_s && (state_r == ST_LOAD || state_r == ST_DISCARD)) begin
         if (cnt_r != 8'd0) cnt_r <= cnt_r - 8'd1;
         if (widx_r != 2'd2) widx_r <= widx_r + 2'd1;
`ifdef PE_CFG_CHECKSUM_EN
         xor_r <= cfg_chk_fold(xor_r, cfg_data);
`endif
         if (state_r == ST_LOAD && widx_r == 2'd0) begin
            sh_ctrl_r <= ctrl_in_s;
            pend_r    <= !alu_func_legal(ctrl_in_s.alu_func);
         end
         if (state_r == ST_LOAD && widx_r == 2'd1) sh_const_r <= cfg_data;
      end
   end

   // Committed outputs, handshake, status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_r   <= '0;
         const_r  <= 32'd0;
         ready_r  <= 1'b0;
         busy_r   <= 1'b0;
         loaded_r <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         ready_r  <= ready_nxt_s;
         busy_r   <= busy_nxt_s;
         loaded_r <= commit_s;
         if (commit_s) begin
            ctrl_r  <= sh_ctrl_r;
            const_r <= sh_const_r;
         end
         if (err_set_s) err_r <= 1'b1;
         else if (err_clr_s) err_r <= 1'b0;
      end
   end

   assign alu_func   = ctrl_r.alu_func;
   assign in_sel     = ctrl_r.in_sel;
   assign out_reg_en = ctrl_r.out_reg_en;
   assign cfg_const  = const_r;
   assign cfg_ready  = ready_r;
   assign cfg_busy   = busy_r;
   assign cfg_loaded = loaded_r;
   assign cfg_err    = err_r;

endmodule

// File: doc/pe_config_loader.md
# pe_config_loader

Configuration-stream consumer for the PE tile: accepts a 32-bit word stream and decodes per-tile frames into the static ALU operation select and operand/constant settings that drive the `ALU` in the PE. It sits between the fabric configuration chain and the PE datapath. It validates each frame, stages the decoded fields and commits them atomically, so the ALU never sees a partially written configuration.

## Interface
- `TILE_ID`, default 0: 8-bit identifier this loader answers to.
- `MAX_WORDS`, default 4: maximum payload words per frame, legal range 2..255.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `cfg_valid` input, 1 bit: stream word valid.
- `cfg_ready` output, 1 bit: loader accepts a word. Transfer occurs when valid and ready are both high on a rising edge.
- `cfg_data` input, 32 bits: stream word.
- `alu_func` output, 3 bits: committed ALU operation, legal values 0..5.
- `in_sel` output, 6 bits: committed operand selects, as {in3_sel, in2_sel, in1_sel} at 2 bits each.
- `out_reg_en` output, 1 bit: committed register-output enable.
- `cfg_const` output, 32 bits: committed constant operand.
- `cfg_loaded` output, 1 bit: one-cycle pulse on each commit.
- `cfg_err` output, 1 bit: sticky frame error flag.
- `cfg_busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- **Header word:**
  - [31:24] sync byte, 0xA5.
  - [23:16] tile id.
  - [15:8] payload count N.
  - [7:0] reserved, ignored.
- **Payload word 0 (control):**
  - [2:0] alu_func.
  - [3] out_reg_en.
  - [9:4] in_sel.
  - [31:10] ignored.
- **Payload word 1:** cfg_const.
- **Payload words 2..N-1:** accepted and discarded.
- **States:** IDLE, LOAD, DISCARD, CHECK (only with checksum), COMMIT.
- **IDLE, word without the sync byte:** dropped; the state stays IDLE.
- **IDLE, header with N<2 or N>MAX_WORDS:** set cfg_err; stay IDLE.
- **IDLE, valid header whose tile id ≠ TILE_ID:** go to DISCARD and consume exactly N words, plus the checksum word if enabled, then return to IDLE. Outputs are not touched; cfg_err is not set.
- **IDLE, valid header whose tile id = TILE_ID:** clear cfg_err; go to LOAD.
- **LOAD:**
  - A down-counter (8 bits) is loaded with N at the header and decrements on each accepted word.
  - Fields go into shadow registers only.
  - After the last word, go to CHECK if the checksum is enabled, otherwise to COMMIT.
- **Illegal alu_func (6 or 7) in the control word:** latch a pending error and continue consuming the frame. At frame end, set cfg_err and return to IDLE without committing.
- **COMMIT:** copy the shadow registers to the outputs, pulse cfg_loaded, return to IDLE.
- **Reset:** all outputs are 0, state is IDLE, shadow registers are 0. Reset asserted mid-frame discards the partial frame. The previously committed values are also lost, because every output resets to 0.

## Timing
- cfg_ready is 1 in IDLE, LOAD and DISCARD, and 0 in CHECK and COMMIT. In reset cfg_ready is 0.
- Final word accepted at edge k → COMMIT entered at edge k. At edge k+1 the outputs update and cfg_loaded rises; it falls at edge k+2.
- The committed outputs are therefore updated 1 edge after the final word (2 edges with checksum).
- Back-to-back frames: the next header is accepted no earlier than edge k+2 (k+3 with checksum), which gives a throughput bubble of 1 cycle (2 with checksum).
- cfg_valid low inside a frame stalls the loader with no timeout.
- cfg_err is set on the edge that detects the error and held until the next matching valid header.

## Configuration
- Macro: `PE_CFG_CHECKSUM_EN`.
- **Defined:**
  - Each frame carries one extra trailing word equal to the XOR of the header and all N payload words.
  - CHECK compares that word against a running XOR.
  - On mismatch: set cfg_err, no commit, return to IDLE.
  - CHECK lasts one cycle with cfg_ready=0.
- **Undefined:** no trailing word, no CHECK state, no XOR register.

## Structure
- **Package `pe_cfg_pkg`:**
  - `PE_CFG_SYNC` = 8'hA5.
  - `ALU_FUNC_MAX` = 3'd5.
  - State enum `pe_cfg_state_t`.
  - Packed struct `pe_cfg_ctrl_t` holding alu_func, out_reg_en and in_sel, including the field bit positions.
- **Sub-module `pe_cfg_hdr_decode`:** combinational header decode producing is_sync, id_match, count_ok and count. It is the natural split; the FSM, counter, shadow registers and commit logic stay in the top module.

## Test plan
- **Good frame, checksum off:** header 0xA5_00_02_00, ctrl 0x0000_0024, const 0xDEAD_BEEF → alu_func=4, in_sel=6'b000010, out_reg_en=0, cfg_const=0xDEADBEEF. cfg_loaded pulses once, exactly 1 edge after the const word.
- **Tile id mismatch:** header 0xA5_07_03_00 followed by 3 words → outputs unchanged, cfg_err=0. The next frame for tile 0 commits normally.
- **Illegal alu_func:** ctrl word with alu_func=6 → frame fully consumed, cfg_err=1, no cfg_loaded, previous outputs retained.
- **Bad count and junk:** header with N=0, then N=9 (MAX_WORDS=4), then a junk word 0x1234_5678 → cfg_err=1, state stays IDLE, cfg_ready stays 1.
- **Stall and reset:** cfg_valid deasserted for 5 cycles mid-LOAD, then completed → correct commit. A second frame is interrupted by rst_n=0 after its control word → all outputs 0, cfg_busy=0.
- **With `PE_CFG_CHECKSUM_EN`:** a correct XOR word commits with latency 2 edges. A corrupted XOR word (bit 0 flipped) sets cfg_err and does not commit.
